mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_if.sv | 29 ++
 rtl/mdu_signfix.sv | 19 +
 rtl/mdu.sv | 206 ++++++++++++++++++++
 tb/tb_mdu.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states, iteration count.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mdu_pkg;

  // Operation codes follow the instruction funct3 field.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIN  = 2'd2
  } mdu_state_e;

  // One product or quotient bit is produced per CALC cycle.
  localparam int MDU_ITER = 32;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MUL (low half is sign-agnostic), MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is treated as signed by MUL, MULH, DIV and REM; MULHSU keeps it unsigned.
  function automatic logic b_is_signed(input mdu_op_e op);
    return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Latency: none (wires only).
// Backpressure: busy holds the requester; start is only sampled while the unit is idle.
interface mdu_if import mdu_pkg::*; #(
  parameter int XLEN = 32
) ();

  logic            start;
  mdu_op_e         op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] C;

  // Pipeline side: issues requests and flushes.
  modport master (
    output start, op, A, B, kill,
    input  busy, done, C
  );

  // Unit side: consumes requests, returns results.
  modport slave (
    input  start, op, A, B, kill,
    output busy, done, C
  );

endinterface

// File: rtl/mdu_signfix.sv
// Two-lane conditional two's-complement negate: magnitudes on the way in, signed results on the way out.
// Latency: combinational.
// Backpressure: none.
module mdu_signfix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a_in,
  input  logic          a_neg,
  input  logic [WB-1:0] b_in,
  input  logic          b_neg,
  output logic [WA-1:0] a_out,
  output logic [WB-1:0] b_out
);

  assign a_out = a_neg ? (~a_in + WA'(1)) : a_in;
  assign b_out = b_neg ? (~b_in + WB'(1)) : b_in;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Latency: 33 cycles from accepting start to done (1 cycle for trivial cases when MDU_EARLY_OUT_EN is defined).
// Backpressure: busy is high while an operation is in flight; start is ignored until the unit is idle.
// Build option: define MDU_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiply in 1 cycle.
module mdu import mdu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rstn,
  mdu_if.slave bus
);

  // Control state and registered outputs.
  mdu_state_e      state;
  logic [4:0]      cnt;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] c_q;

  // Operation context captured at acceptance.
  mdu_op_e         op_q;
  logic            qneg_q;   // negate product / quotient at the end
  logic            rneg_q;   // negate remainder at the end (dividend sign)

  // Datapath. For multiply, opnd_q is the multiplicand and prod_q the 64-bit product
  // shift register. For divide, opnd_q is the divisor, prod_q[XLEN-1:0] shifts the
  // dividend out and the quotient in, and rem_q holds the running remainder.
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;

  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     part_rem;
  logic [XLEN:0]     trial;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  logic [2*XLEN-1:0] res_prod;
  logic [XLEN-1:0]   res_rem;
  logic [XLEN-1:0]   result;

  assign accept = (state == MDU_IDLE) && bus.start && !bus.kill;
  assign a_neg  = bus.A[XLEN-1] & a_is_signed(bus.op);
  assign b_neg  = bus.B[XLEN-1] & b_is_signed(bus.op);
  assign b_zero = (bus.B == '0);

  // Signed operands become magnitudes; the sign is reapplied at the end.
  mdu_signfix #(.WA(XLEN), .WB(XLEN)) u_in_fix (
    .a_in  (bus.A),
    .a_neg (a_neg),
    .b_in  (bus.B),
    .b_neg (b_neg),
    .a_out (mag_a),
    .b_out (mag_b)
  );

`ifdef MDU_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic early;
  assign early = op_is_div(bus.op)
               ? (b_zero || ((bus.op == MDU_DIV || bus.op == MDU_REM) &&
                             bus.A == MIN_NEG && bus.B == '1))
               : (bus.A == '0 || b_zero);
`endif

  // One iteration step for each algorithm, evaluated from the current registers.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, prod_q[XLEN-1:1]};
    // 33-bit partial remainder: running remainder with the next dividend bit appended.
    part_rem = {rem_q, prod_q[XLEN-1]};
    trial    = part_rem - {1'b0, opnd_q};
    // While the remainder stays below the divisor, the top bit of the trial is a
    // clean borrow. With a zero divisor rem_q[XLEN-1] stays clear until the last step,
    // so every trial succeeds and the quotient fills with ones while the remainder
    // collects the dividend, which is exactly the required divide-by-zero result.
    rem_ge   = ~trial[XLEN];
    rem_next = rem_ge ? trial[XLEN-1:0] : part_rem[XLEN-1:0];
    quo_next = {prod_q[XLEN-2:0], rem_ge};
  end

  // Operand capture on acceptance, then one multiply or divide step per CALC cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q   <= MDU_MUL;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      opnd_q <= '0;
      prod_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      op_q   <= bus.op;
      rneg_q <= a_neg;
      // A zero divisor must yield all-ones regardless of the dividend sign.
      qneg_q <= (a_neg ^ b_neg) & ~(op_is_div(bus.op) & b_zero);
      rem_q  <= '0;
      if (op_is_div(bus.op)) begin
        opnd_q <= mag_b;
        prod_q <= {{XLEN{1'b0}}, mag_a};
      end else begin
        opnd_q <= mag_a;
        prod_q <= {{XLEN{1'b0}}, mag_b};
      end
`ifdef MDU_EARLY_OUT_EN
      // Preload the magnitudes the full iteration would have produced.
      if (early) begin
        if (op_is_div(bus.op)) begin
          prod_q <= {{XLEN{1'b0}}, (b_zero ? {XLEN{1'b1}} : MIN_NEG)};
          rem_q  <= b_zero ? mag_a : '0;
        end else begin
          prod_q <= '0;
        end
      end
`endif
    end else if (state == MDU_CALC) begin
      if (op_is_div(op_q)) begin
        prod_q[XLEN-1:0] <= quo_next;
        rem_q            <= rem_next;
      end else begin
        prod_q <= mul_next;
      end
    end
  end

  // The upper half of prod_q is zero for divides, so a full-width negate also fixes the quotient.
  mdu_signfix #(.WA(2*XLEN), .WB(XLEN)) u_out_fix (
    .a_in  (prod_q),
    .a_neg (qneg_q),
    .b_in  (rem_q),
    .b_neg (rneg_q),
    .a_out (res_prod),
    .b_out (res_rem)
  );

  // Pick the result half that the latched operation returns.
  always_comb begin
    result = res_prod[XLEN-1:0];
    case (op_q)
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = res_prod[2*XLEN-1:XLEN];
      MDU_REM, MDU_REMU:               result = res_rem;
      default:                         result = res_prod[XLEN-1:0];
    endcase
  end

  // Sequencing: IDLE accepts, CALC counts MDU_ITER steps, FIN registers C and pulses done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      c_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.kill) begin
        state  <= MDU_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          MDU_IDLE: begin
            if (bus.start) begin
              cnt    <= '0;
              busy_q <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
              state  <= early ? MDU_FIN : MDU_CALC;
`else
              state  <= MDU_CALC;
`endif
            end
          end
          MDU_CALC: begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'(MDU_ITER - 1)) begin
              state <= MDU_FIN;
            end
          end
          MDU_FIN: begin
            c_q    <= result;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= MDU_IDLE;
          end
          default: begin
            state  <= MDU_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.C    = c_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed RV32M vectors, random ops against a reference model, flow-control cases.
// Latency: expects 33 cycles per op, or 1 for the trivial cases when MDU_EARLY_OUT_EN is defined.
// Backpressure: issues only while idle or in the done cycle; also pokes start while busy.
module tb_mdu;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] c;
    int          acc;
    int          lat;
  } exp_t;

`ifdef MDU_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif
  localparam int FULL_LAT = 33;
  localparam int NDIR = 13;

  localparam logic [2:0] DIR_OP [NDIR] = '{
    3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0
  };
  localparam logic [31:0] DIR_A [NDIR] = '{
    32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
    32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0
  };
  localparam logic [31:0] DIR_B [NDIR] = '{
    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h0001_2345
  };
  localparam logic [31:0] DIR_C [NDIR] = '{
    32'hFFFF_FFEB, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd0
  };

  logic        clk = 1'b0;
  logic        rstn;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic        prev_done = 1'b0;
  logic [31:0] last_c = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  mdu_if #(.XLEN(32)) bus ();

  mdu #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference results computed with wide arithmetic, special cases from the ISA.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    logic signed [63:0] ub;
    logic [63:0]        p;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    if (op[2]) special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       special = (a == 32'd0) || (b == 32'd0);
    return special ? EO_LAT : FULL_LAT;
  endfunction

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input int lat);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = mdu_op_e'(op);
    bus.A     = a;
    bus.B     = b;
    e.c   = c;
    e.acc = cyc + 1;
    e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", {31'b0, bus.done}, 32'd1);
  endtask

  // Scoreboard side: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rstn && bus.done) begin
      n_done++;
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      chk("busy_low_in_done", {31'b0, bus.busy}, 32'd0);
      chk("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("result", bus.C, mon_e.c);
        chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        last_c = mon_e.c;
      end
    end
    prev_done = bus.done;
  end

  initial begin
    int n0;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    bus.op    = MDU_MUL;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_c", bus.C, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors, including divide-by-zero, overflow and zero-operand multiply.
    for (int i = 0; i < NDIR; i++) begin
      issue(DIR_OP[i], DIR_A[i], DIR_B[i], DIR_C[i], lat_of(DIR_OP[i], DIR_A[i], DIR_B[i]));
      drain(100);
    end

    // Random operations against the reference model, with corner operands mixed in.
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (i % 5 == 1) ? 32'h8000_0000 : ((i % 7 == 3) ? 32'd0 : $urandom);
      rb  = (i % 4 == 0) ? 32'd0 : ((i % 5 == 1) ? 32'hFFFF_FFFF : $urandom);
      issue(rop, ra, rb, model(rop, ra, rb), lat_of(rop, ra, rb));
      drain(100);
    end

    // start while busy is ignored; the original divide completes unchanged.
    n0 = n_done;
    issue(3'd4, 32'd100, 32'd7, 32'd14, FULL_LAT);
    repeat (9) @(negedge clk);
    chk("busy_during_calc", {31'b0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.op    = MDU_MUL;
    bus.A     = 32'd3;
    bus.B     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    drain(100);
    repeat (40) @(negedge clk);
    chk("ignored_start_dones", 32'(n_done - n0), 32'd1);

    // kill mid-calculation: no done, busy drops, C keeps the last result.
    n0 = n_done;
    bus.start = 1'b1;
    bus.op    = MDU_DIV;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    chk("busy_before_kill", {31'b0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    chk("kill_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_dones", 32'(n_done - n0), 32'd0);
    chk("kill_keeps_c", bus.C, last_c);

    // kill wins over a simultaneous start.
    n0 = n_done;
    bus.start = 1'b1;
    bus.kill  = 1'b1;
    bus.op    = MDU_MUL;
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("kill_start_busy", {31'b0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_start_dones", 32'(n_done - n0), 32'd0);

    // Back-to-back: second start raised in the done cycle of the first.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
    wait_done(60);
    issue(3'd5, 32'd1000, 32'd3, 32'd333, FULL_LAT);
    drain(100);

    // Asynchronous reset in the middle of CALC clears outputs immediately.
    @(negedge clk);
    issue(3'd0, 32'd123, 32'd456, 32'd56088, FULL_LAT);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_c", bus.C, 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    last_c = '0;
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 32'd14, FULL_LAT);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
